// File: rtl/tt_serial_adder.sv
// Bit-serial adder tile: latches two operands on a start rising edge, adds them
// LSB-first one bit per enabled cycle, then publishes the (WIDTH+1)-bit sum.
module tt_serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic             start_q_reg;
  logic             armed_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [WIDTH:0]   result_reg;
  logic [2:0]       op_cnt_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] work_next;
  logic [4:0]       result_low;
  logic             half_sum;
  logic             sum_bit;
  logic             carry_next;
  logic             trigger;
  logic             last_bit;
  logic             unused_inputs;

  // Operands live in the two nibbles of ui_in; narrower/wider widths are zero-fitted.
  generate
    if (WIDTH == 4) begin : g_op_exact
      assign a_in = ui_in[3:0];
      assign b_in = ui_in[7:4];
    end else if (WIDTH < 4) begin : g_op_narrow
      assign a_in = ui_in[WIDTH-1:0];
      assign b_in = ui_in[WIDTH+3:4];
    end else begin : g_op_wide
      assign a_in = {{(WIDTH-4){1'b0}}, ui_in[3:0]};
      assign b_in = {{(WIDTH-4){1'b0}}, ui_in[7:4]};
    end

    if (WIDTH >= 4) begin : g_res_wide
      assign result_low = result_reg[4:0];
    end else begin : g_res_narrow
      assign result_low = {{(4-WIDTH){1'b0}}, result_reg};
    end

    if (WIDTH == 1) begin : g_work_one
      assign work_next = sum_bit;
    end else begin : g_work_multi
      assign work_next = {sum_bit, work_reg[WIDTH-1:1]};
    end
  endgenerate

  // Two cascaded half adders; the carry is the OR of both half-adder carries.
  assign half_sum   = a_reg[0] ^ b_reg[0];
  assign sum_bit    = half_sum ^ carry_reg;
  assign carry_next = (a_reg[0] & b_reg[0]) | (half_sum & carry_reg);

  // armed_reg blocks a start that was already high when reset released.
  assign trigger  = uio_in[0] & ~start_q_reg & armed_reg;
  assign last_bit = (bit_cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      start_q_reg <= 1'b0;
      armed_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      work_reg    <= '0;
      carry_reg   <= 1'b0;
      bit_cnt_reg <= '0;
      result_reg  <= '0;
      op_cnt_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else if (ena) begin
      start_q_reg <= uio_in[0];
      if (!uio_in[0]) begin
        armed_reg <= 1'b1;
      end
      case (state_reg)
        IDLE, DONE: begin
          if (trigger) begin
            a_reg       <= a_in;
            b_reg       <= b_in;
            work_reg    <= '0;
            carry_reg   <= 1'b0;
            bit_cnt_reg <= '0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          work_reg    <= work_next;
          a_reg       <= a_reg >> 1;
          b_reg       <= b_reg >> 1;
          carry_reg   <= carry_next;
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          if (last_bit) begin
            result_reg <= {carry_next, work_next};
            op_cnt_reg <= op_cnt_reg + 3'd1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign uo_out  = {op_cnt_reg, result_low};
  assign uio_out = {4'b0000, done_reg, busy_reg, 2'b00};
  assign uio_oe  = 8'b0000_1100;

  assign unused_inputs = &{1'b0, uio_in[7:1]};

endmodule
